// File: rtl/bit_serial_adder_ctrl.sv
// rtl/bit_serial_adder_ctrl.sv - WIDTH-bit add/subtract sequenced LSB-first through one 1-bit full adder
// FullAdder is the shared 1-bit cell; the controller owns every shift register, the carry and the counter.

module FullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (a & cin) | (b & cin);
endmodule

module bit_serial_adder_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] res_shift;

    FullAdder u_fa (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .cin   (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        // Result fills from the top so bit 0 lands in place after WIDTH shifts.
        res_shift            = res_sh_q >> 1;
        res_shift[WIDTH-1]   = fa_sum;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    a_sh_d  = a;
                    b_sh_d  = op_sub ? ~b : b;
                    carry_d = op_sub;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                res_sh_d = res_shift;
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                carry_d  = fa_carry;
                if (cnt_q == LAST) begin
                    // carry_q here is the carry into the MSB.
                    state_d = S_DONE;
                    cout_d  = fa_carry;
                    ovf_d   = carry_q ^ fa_carry;
                    zero_d  = (res_shift == '0);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign result    = res_sh_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// tb/tb_bit_serial_adder_ctrl.sv - scoreboard bench for bit_serial_adder_ctrl at WIDTH=8

module tb_bit_serial_adder_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         zero;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         o;
        logic         z;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    bit_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every done cycle is matched against the oldest expected result.
    always @(negedge clk) begin
        if (done) begin
            check("done_not_busy", 32'(busy), 32'd0);
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("result",    32'(result),    32'(mon_e.res));
                check("carry_out", 32'(carry_out), 32'(mon_e.c));
                check("overflow",  32'(overflow),  32'(mon_e.o));
                check("zero",      32'(zero),      32'(mon_e.z));
            end
        end
    end

    task automatic do_op(input logic sub, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] r, input logic c, input logic o, input logic z,
                         input string tag);
        int n;
        int bc;
        sb_q.push_back('{r, c, o, z});
        op_sub = sub;
        a      = x;
        b      = y;
        start  = 1'b1;
        cyc();
        start  = 1'b0;
        n  = 1;
        bc = 0;
        while (!done && n < 40) begin
            if (busy) bc++;
            cyc();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd9);
        check({tag, "_busy_cycles"}, 32'(bc), 32'd8);
        cyc();
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 40) begin
            cyc();
            n++;
        end
        check("wait_done_seen", 32'(done), 32'd1);
    endtask

    initial begin
        int dc;
        rst    = 1'b1;
        start  = 1'b0;
        op_sub = 1'b0;
        a      = '0;
        b      = '0;
        repeat (3) cyc();
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_done",      32'(done),      32'd0);
        check("rst_result",    32'(result),    32'd0);
        check("rst_carry_out", 32'(carry_out), 32'd0);
        check("rst_overflow",  32'(overflow),  32'd0);
        check("rst_zero",      32'(zero),      32'd0);

        // rst and start on the same edge: reset wins.
        start = 1'b1;
        a     = 8'h7F;
        b     = 8'h01;
        cyc();
        rst   = 1'b0;
        start = 1'b0;
        check("rst_start_busy", 32'(busy), 32'd0);
        cyc();
        check("rst_start_busy2", 32'(busy), 32'd0);

        do_op(1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, "add_7f_01");
        do_op(1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, "add_ff_01");
        do_op(1'b1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1, "sub_05_05");
        do_op(1'b1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0, "sub_00_01");
        do_op(1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0, "sub_80_01");

        // Handshake: start pulses in RUN and DONE are ignored.
        sb_q.push_back('{8'h30, 1'b0, 1'b0, 1'b0});
        op_sub = 1'b0;
        a      = 8'h10;
        b      = 8'h20;
        start  = 1'b1;
        cyc();
        start  = 1'b0;
        repeat (3) cyc();
        check("hs_busy_run", 32'(busy), 32'd1);
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
        cyc();
        start = 1'b0;
        wait_done();
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
        cyc();
        check("hs_idle_busy",   32'(busy),   32'd0);
        check("hs_idle_done",   32'(done),   32'd0);
        check("hs_idle_result", 32'(result), 32'h30);
        sb_q.push_back('{8'h03, 1'b0, 1'b0, 1'b0});
        a = 8'h01;
        b = 8'h02;
        cyc();
        start = 1'b0;
        check("hs_b2b_accept", 32'(busy), 32'd1);
        wait_done();
        cyc();

        // Reset abort mid-RUN.
        do_op(1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, "pre_abort");
        op_sub = 1'b0;
        a      = 8'h12;
        b      = 8'h34;
        start  = 1'b1;
        cyc();
        start  = 1'b0;
        repeat (3) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("abort_busy",      32'(busy),      32'd0);
        check("abort_done",      32'(done),      32'd0);
        check("abort_result",    32'(result),    32'd0);
        check("abort_carry_out", 32'(carry_out), 32'd0);
        check("abort_overflow",  32'(overflow),  32'd0);
        check("abort_zero",      32'(zero),      32'd0);
        dc = 0;
        repeat (20) begin
            cyc();
            if (done) dc++;
        end
        check("abort_no_done", 32'(dc), 32'd0);
        do_op(1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0, "post_abort");

        check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/bit_serial_adder_ctrl.md
# bit_serial_adder_ctrl

Multi-cycle sequencer that computes a WIDTH-bit add or subtract by time-multiplexing one instance of the team's 1-bit `FullAdder` over all bit positions, LSB first. It owns the operand and result shift registers, the carry register and the bit counter, and exposes a start/busy/done handshake. It serves area-constrained arithmetic paths in the pipelined RISC-V core and is the template for later multi-cycle units.

## Interface
- `WIDTH`, default 32: operand and result width in bits; legal range ≥1.
- `clk`  input  1  clock, all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request a new operation; sampled only in IDLE.
- `op_sub`  input  1  0 = A+B, 1 = A−B; sampled with `start`.
- `a`  input  WIDTH  operand A; sampled with `start`.
- `b`  input  WIDTH  operand B; sampled with `start`.
- `busy`  output  1  high in RUN.
- `done`  output  1  one-cycle pulse; result and flags valid.
- `result`  output  WIDTH  sum/difference, held until the next accepted `start`.
- `carry_out`  output  1  final carry; for SUB, 1 = no borrow.
- `overflow`  output  1  signed overflow (carry into MSB XOR carry out of MSB).
- `zero`  output  1  `result` == 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: if `start`=1, accept the operation and go to RUN.
  - Latch `a` into the A shift register and `b` (or `~b` when `op_sub`) into the B shift register.
  - Set the carry register to `op_sub` and the bit counter to 0.
  - Otherwise stay in IDLE.
- RUN, every cycle:
  - The single `FullAdder` takes A[0], B[0] and the carry register.
  - On the edge, `sum` shifts into the MSB of the result shift register, A and B shift right by 1, `carry` loads into the carry register, and the counter increments.
  - When the counter is at WIDTH−1 on that edge, capture the final carry into `carry_out`, capture the carry into the MSB (the carry register value before this edge), and go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Flags:
  - `overflow` = carry-into-MSB XOR `carry_out`.
  - `zero` is computed from the complete result and registered on the same edge that enters DONE.
  - `result`, `carry_out`, `overflow` and `zero` are stable from the first DONE cycle until the edge that accepts the next `start`.
- `start` in RUN or DONE is ignored. It is not queued.
- The counter width is clog2(WIDTH), minimum 1. The counter never wraps during an operation.
- WIDTH=1: one RUN cycle; carry-into-MSB equals the initial carry (`op_sub`).

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, `carry_out`=0, `overflow`=0, `zero`=0, and all internal registers 0.
- Latency, with `start` accepted on edge E0:
  - RUN covers the cycles after E0 through E(WIDTH−1).
  - Bit i is registered on edge E(i+1).
  - `done` is high in the cycle after E(WIDTH).
  - The next `start` is accepted at the earliest on E(WIDTH+2).
- Accepted-`start`-to-`done` is WIDTH+1 cycles. Throughput is one operation per WIDTH+2 cycles.
- `busy` and `done` are never high together.
- `rst` in any state, including mid-RUN: on the next edge, force all reset values. The aborted operation produces no `done` and no partial `result`.
- `rst` and `start` high on the same edge: reset wins and the operation is not accepted.
- Outputs are registered. No combinational path exists from inputs to outputs.

## Test plan
All cases use WIDTH=8.
1. ADD 0x7F + 0x01 → `result`=0x80, `carry_out`=0, `overflow`=1, `zero`=0. `done` pulses exactly 9 cycles after the accepting edge, and `busy` is high for 8 cycles.
2. ADD 0xFF + 0x01 → `result`=0x00, `carry_out`=1, `overflow`=0, `zero`=1.
3. SUB 0x05 − 0x05 → `result`=0x00, `carry_out`=1, `zero`=1. SUB 0x00 − 0x01 → `result`=0xFF, `carry_out`=0, `overflow`=0.
4. SUB 0x80 − 0x01 → `result`=0x7F, `overflow`=1, `carry_out`=1.
5. Handshake:
   - Start ADD 0x10 + 0x20.
   - Pulse `start` with a=0xAA, b=0x55 during RUN and again in DONE.
   - Required: `result`=0x30, no second `done`, and outputs held in IDLE.
   - A back-to-back `start` on the first IDLE cycle is then accepted.
6. Reset abort:
   - Run ADD 0x7F + 0x01 to completion (outputs 0x80 / `overflow`=1).
   - Start ADD 0x12 + 0x34 and assert `rst` in RUN cycle 4.
   - Required: all outputs 0 on the next cycle, and no `done` for 20 cycles.
   - A new `start` with 0x12 + 0x34 then returns 0x46.
